// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared ALU opcode and arbiter state types
package alu_share_arbiter_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      kADD = 4'd0,
      kXOR = 4'd1,
      kORR = 4'd2,
      kBGT = 4'd3,
      kBNE = 4'd4,
      kSLL = 4'd5,
      kSRL = 4'd6,
      kXXR = 4'd7,
      kSUB = 4'd8,
      kAND = 4'd9
   } op_mne;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

`ifdef ALU_OPCHK_EN
   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      case (op)
         kADD, kXOR, kORR, kBGT, kBNE, kSLL, kSRL, kXXR, kSUB, kAND: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
`endif

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// rtl/alu_share_arbiter_rr_pick.sv - combinational round-robin picker
// Grants the first valid index at or after ptr_i, wrapping modulo NREQ.
module alu_share_arbiter_rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [NREQ-1:0] rot;
   int              sel;

   // Rotate so that bit 0 is the requester at ptr_i; lowest set bit wins.
   assign rot   = NREQ'({valid_i, valid_i} >> ptr_i);
   assign any_o = |rot;

   always_comb begin
      sel = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sel = int'(ptr_i) + k;
         end
      end
      if (sel >= NREQ) begin
         sel = sel - NREQ;
      end
      idx_o   = IDW'(sel);
      grant_o = any_o ? (NREQ'(1) << sel) : '0;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU
// Optional opcode checking is enabled with the ALU_OPCHK_EN macro.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int W    = 8,
   parameter int Ops  = 4,
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*Ops-1:0] req_op,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [Ops-1:0]    alu_op,
   output logic [W-1:0]      alu_a,
   output logic [W-1:0]      alu_b,
   input  logic [W-1:0]      alu_out,
   input  logic              alu_jump,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_jump,
   output logic              rsp_err
);

   arb_state_e      state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [Ops-1:0]  op_q, op_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [W-1:0]    rsp_data_q, rsp_data_d;
   logic            rsp_jump_q, rsp_jump_d;
`ifdef ALU_OPCHK_EN
   logic            err_q, err_d;
   logic            rsp_err_q, rsp_err_d;
`endif

   logic [NREQ-1:0] pick_grant;
   logic [IDW-1:0]  pick_idx;
   logic            pick_any;
   logic            arb_en;
   logic            grant;
   logic [Ops-1:0]  sel_op;
   logic [W-1:0]    sel_a, sel_b;

   alu_share_arbiter_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Arbitration happens when idle, or in the cycle the held response retires.
   assign arb_en    = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
   assign grant     = arb_en && pick_any;
   assign req_ready = (Reset_n && arb_en) ? pick_grant : '0;

   assign sel_op = Ops'(req_op >> (int'(pick_idx) * Ops));
   assign sel_a  = W'(req_a >> (int'(pick_idx) * W));
   assign sel_b  = W'(req_b >> (int'(pick_idx) * W));

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_jump_d  = rsp_jump_q;
`ifdef ALU_OPCHK_EN
      err_d       = err_q;
      rsp_err_d   = rsp_err_q;
`endif

      case (state_q)
         IDLE: begin
            if (grant) state_d = ISSUE;
         end
         ISSUE: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
`ifdef ALU_OPCHK_EN
            rsp_data_d  = err_q ? '0 : alu_out;
            rsp_jump_d  = !err_q && alu_jump;
            rsp_err_d   = err_q;
`else
            rsp_data_d  = alu_out;
            rsp_jump_d  = alu_jump;
`endif
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = grant ? ISSUE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant) begin
         op_d     = sel_op;
         a_d      = sel_a;
         b_d      = sel_b;
         id_d     = pick_idx;
         rr_ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
`ifdef ALU_OPCHK_EN
         err_d    = 1'b0;
         // Unknown opcodes still take a slot but feed the ALU a harmless add.
         if (!op_is_legal(OP_W'(sel_op))) begin
            op_d  = Ops'(kADD);
            a_d   = '0;
            b_d   = '0;
            err_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_jump_q  <= 1'b0;
`ifdef ALU_OPCHK_EN
         err_q       <= 1'b0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_jump_q  <= rsp_jump_d;
`ifdef ALU_OPCHK_EN
         err_q       <= err_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign alu_op    = op_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_jump  = rsp_jump_q;
`ifdef ALU_OPCHK_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int W    = 8;
   localparam int OPS  = 4;
   localparam int NREQ = 2;
   localparam int IDW  = 1;

   logic                Clk = 1'b0;
   logic                Reset_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*OPS-1:0] req_op;
   logic [NREQ*W-1:0]   req_a;
   logic [NREQ*W-1:0]   req_b;
   logic [OPS-1:0]      alu_op;
   logic [W-1:0]        alu_a;
   logic [W-1:0]        alu_b;
   logic [W-1:0]        alu_out;
   logic                alu_jump;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [W-1:0]        rsp_data;
   logic                rsp_jump;
   logic                rsp_err;

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
      logic           jump;
      logic           err;
      int             cyc;
   } sb_t;

   sb_t            sb[$];
   int             grants[$];
   int             resp_ids[$];
   int             vectors = 0;
   int             miscompares = 0;
   int             cyc = 0;
   int             mstate = 0;
   int             exp_ptr = 0;
   logic           prev_valid = 1'b0;
   logic [OPS-1:0] m_op;
   logic [W-1:0]   m_a, m_b;
   logic [W-1:0]   last_data;
   logic           last_jump, last_err;
   logic [IDW-1:0] last_id;
   int             gs;

   always #5 Clk = ~Clk;

   alu_share_arbiter #(.W(W), .Ops(OPS), .NREQ(NREQ), .IDW(IDW)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_out   (alu_out),
      .alu_jump  (alu_jump),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_jump  (rsp_jump),
      .rsp_err   (rsp_err)
   );

   // Reference ALU: branch ops report only the compare, others flag a nonzero result.
   function automatic logic [W:0] alu_f(input logic [OPS-1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      logic [W-1:0] r;
      logic         j;
      r = '0;
      j = 1'b0;
      case (op)
         kADD: r = a + b;
         kXOR: r = a ^ b;
         kORR: r = a | b;
         kBGT: j = (a > b);
         kBNE: j = (a != b);
         kSLL: r = a << b[2:0];
         kSRL: r = a >> b[2:0];
         kXXR: r = ~(a ^ b);
         kSUB: r = a - b;
         kAND: r = a & b;
         default: r = 8'hA5;
      endcase
      if (op != kBGT && op != kBNE) j = (r != '0);
      return {j, r};
   endfunction

   always_comb {alu_jump, alu_out} = alu_f(alu_op, alu_a, alu_b);

   function automatic logic is_illegal(input logic [OPS-1:0] op);
`ifdef ALU_OPCHK_EN
      return op > 4'd9;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [NREQ-1:0] exp_rdy;
      int              g;
      int              j;
      sb_t             e;
      logic [OPS-1:0]  gop;
      logic [W-1:0]    ga, gb;
      logic [W:0]      r;
      #1;
      g = -1;
      if (mstate == 0 || (mstate == 2 && rsp_ready)) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (exp_ptr + k) % NREQ;
            if (g < 0 && ((req_valid >> j) & NREQ'(1)) != '0) g = j;
         end
      end
      exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(mstate == 2));
      if (mstate == 1) begin
         chk("alu_op", 32'(alu_op), 32'(m_op));
         chk("alu_a", 32'(alu_a), 32'(m_a));
         chk("alu_b", 32'(alu_b), 32'(m_b));
      end
      if (rsp_valid && !prev_valid && sb.size() > 0)
         chk("latency", 32'(cyc - sb[0].cyc), 32'd2);
      if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_underflow observed=response expected=none");
         end else begin
            e = sb.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_jump", 32'(rsp_jump), 32'(e.jump));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            last_id   = rsp_id;
            last_data = rsp_data;
            last_jump = rsp_jump;
            last_err  = rsp_err;
            resp_ids.push_back(int'(rsp_id));
         end
      end
      prev_valid = rsp_valid;
      if (g >= 0) begin
         gop   = OPS'(req_op >> (g * OPS));
         ga    = W'(req_a >> (g * W));
         gb    = W'(req_b >> (g * W));
         r     = alu_f(gop, ga, gb);
         e.id  = IDW'(g);
         e.cyc = cyc;
         if (is_illegal(gop)) begin
            e.data = '0; e.jump = 1'b0; e.err = 1'b1;
            m_op = kADD; m_a = '0; m_b = '0;
         end else begin
            e.data = r[W-1:0]; e.jump = r[W]; e.err = 1'b0;
            m_op = gop; m_a = ga; m_b = gb;
         end
         sb.push_back(e);
         grants.push_back(g);
         exp_ptr = (g + 1) % NREQ;
      end
      case (mstate)
         0: if (g >= 0) mstate = 1;
         1: mstate = 2;
         2: if (rsp_ready) mstate = (g >= 0) ? 1 : 0;
         default: mstate = 0;
      endcase
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && (sb.size() > 0 || rsp_valid); i++) step();
      chk("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   task automatic issue1(input int id, input logic [OPS-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      req_op    = (NREQ*OPS)'(op) << (id * OPS);
      req_a     = (NREQ*W)'(a) << (id * W);
      req_b     = (NREQ*W)'(b) << (id * W);
      req_valid = NREQ'(1) << id;
      step();
      req_valid = '0;
      drain();
   endtask

   initial begin
      Reset_n   = 1'b0;
      req_valid = '1;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_jump", 32'(rsp_jump), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      req_valid = '0;
      Reset_n   = 1'b1;
      @(negedge Clk);

      issue1(0, kADD, 8'h3C, 8'h05);
      chk("add_data", 32'(last_data), 32'h41);
      chk("add_id", 32'(last_id), 32'd0);
      chk("add_jump", 32'(last_jump), 32'd1);

      issue1(1, kSUB, 8'h03, 8'h05);
      chk("sub_data", 32'(last_data), 32'hFE);
      chk("sub_id", 32'(last_id), 32'd1);
      issue1(1, kBGT, 8'h07, 8'h09);
      chk("bgt_data", 32'(last_data), 32'h00);
      chk("bgt_jump", 32'(last_jump), 32'd0);

      // Both requesters contending with fresh operands every cycle.
      gs = resp_ids.size();
      req_valid = '1;
      for (int i = 0; i < 40 && grants.size() < 9; i++) begin
         req_op = {4'($urandom_range(9)), 4'($urandom_range(9))};
         req_a  = 16'($urandom);
         req_b  = 16'($urandom);
         step();
      end
      req_valid = '0;
      drain();
      chk("rr_count", 32'(resp_ids.size() - gs), 32'd6);
      for (int i = 0; i < 6 && gs + i < resp_ids.size(); i++)
         chk("rr_order", 32'(resp_ids[gs + i]), 32'(i % 2));

      // Consumer stall with both requesters pending.
      req_op    = {4'(kAND), 4'(kORR)};
      req_a     = {8'hF3, 8'h21};
      req_b     = {8'h3C, 8'h42};
      req_valid = '1;
      rsp_ready = 1'b0;
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         if (sb.size() > 0) begin
            chk("stall_data", 32'(rsp_data), 32'(sb[0].data));
            chk("stall_id", 32'(rsp_id), 32'(sb[0].id));
            chk("stall_jump", 32'(rsp_jump), 32'(sb[0].jump));
         end
      end
      rsp_ready = 1'b1;
      #1;
      chk("grant_on_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      drain();

      // Reset while an XOR is in flight.
      issue1(0, kXOR, 8'hF0, 8'h0F);
      req_op    = 8'(kXOR);
      req_a     = 16'h00F0;
      req_b     = 16'h000F;
      req_valid = 2'b01;
      step();
      req_valid = 2'b11;
      #2 Reset_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_alu_op", 32'(alu_op), 32'd0);
      chk("midrst_alu_a", 32'(alu_a), 32'd0);
      @(negedge Clk);
      Reset_n    = 1'b1;
      sb.delete();
      mstate     = 0;
      exp_ptr    = 0;
      prev_valid = 1'b0;
      req_op     = {4'(kAND), 4'(kADD)};
      req_a      = {8'hFF, 8'h01};
      req_b      = {8'h0F, 8'h02};
      step();
      req_valid = '0;
      drain();
      chk("post_rst_id", 32'(last_id), 32'd0);
      chk("post_rst_data", 32'(last_data), 32'h03);

      issue1(1, 4'hF, 8'h33, 8'h44);
`ifdef ALU_OPCHK_EN
      chk("illegal_err", 32'(last_err), 32'd1);
      chk("illegal_data", 32'(last_data), 32'h00);
      chk("illegal_jump", 32'(last_jump), 32'd0);
`else
      chk("illegal_err", 32'(last_err), 32'd0);
      chk("illegal_data", 32'(last_data), 32'hA5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU among NREQ requesters (e.g. the core datapath and a debug/test port) with round-robin arbitration. Accepts one request per grant over a valid/ready handshake and drives the registered operands onto the ALU. Captures the ALU result and Jump flag into a response register held until the consumer accepts it. Sits between the requesters and the one ALU instance.

Parameters:
W, 8, operand/result width (matches ALU W)
Ops, 4, opcode width (matches ALU Ops)
NREQ, 2, number of requesters (2..8)
IDW, 1, width of rsp_id; must be >= clog2(NREQ)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant; handshake when valid & ready
req_op  in  NREQ*Ops  opcode of requester i at [i*Ops +: Ops]
req_a  in  NREQ*W  operand A of requester i at [i*W +: W]
req_b  in  NREQ*W  operand B of requester i at [i*W +: W]
alu_op  out  Ops  to ALU OP
alu_a  out  W  to ALU InputA
alu_b  out  W  to ALU InputB
alu_out  in  W  from ALU Out
alu_jump  in  1  from ALU Jump
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  index of the requester that owns the response
rsp_data  out  W  captured ALU result
rsp_jump  out  1  captured Jump (branch-taken) flag
rsp_err  out  1  illegal-opcode flag (tied 0 without ALU_OPCHK_EN)

Behaviour:
- Reset (Reset_n low, async): state=IDLE, rr_ptr=0, operand regs (op/a/b)=0, rsp_valid/rsp_id/rsp_data/rsp_jump/rsp_err=0, req_ready=0.
- alu_op/alu_a/alu_b are always driven from the operand registers.
- FSM states IDLE, ISSUE, RESP.
- IDLE: if any req_valid, grant the first valid index searching rr_ptr, rr_ptr+1, ... mod NREQ. req_ready is one-hot, combinational, and only asserted on a valid line. At the edge: capture that requester's op/a/b, record its id, set rr_ptr=(id+1) mod NREQ, go ISSUE. No valid: stay IDLE, req_ready=0.
- ISSUE: req_ready=0. At the edge: rsp_data<=alu_out, rsp_jump<=alu_jump, rsp_id<=id, rsp_valid<=1, go RESP.
- RESP: outputs stable while rsp_valid & !rsp_ready. No grant is issued.
- RESP with rsp_ready=1: response retires at the edge. In the same cycle, arbitrate as in IDLE. If a grant is issued, go ISSUE; else go IDLE. rsp_valid clears at the edge unless a new response is being written, which cannot happen from RESP.
- Latency: request accepted at edge E0 -> rsp_valid high after E1 (2 cycles). Peak throughput is one op per 2 cycles with rsp_ready held high.
- Requesters may drop req_valid at any time before their grant. The arbiter never latches an ungranted request.
- Arithmetic and flags are the ALU's. This block does no width changes on data.
- Reset asserted mid-ISSUE/RESP: in-flight operation is discarded, no response is produced, and all outputs return to reset values.

Optional Feature:
ALU_OPCHK_EN. When defined, an opcode that is not one of the shared op_mne mnemonics (kADD, kXOR, kORR, kBGT, kBNE, kSLL, kSRL, kXXR, kSUB, kAND) is still granted and follows the same timing. Its response has rsp_err=1, rsp_data=0 and rsp_jump=0, and alu_op is driven as kADD with zero operands, so X never reaches the ALU. When undefined, rsp_err is tied 0 and the opcode passes through unchecked.

Decomposition:
- Shared package Definitions: the op_mne enum, which already exists, plus a new arb_state_e enum (IDLE, ISSUE, RESP) for waveform viewing.
- Under ALU_OPCHK_EN, the package also holds a function op_is_legal(op) returning 1 for enumerated values.
- One sub-module: rr_pick. It is combinational, takes the valid vector and rr_ptr, and outputs a one-hot grant and an index.

Test Plan:
- Req0: kADD, A=8'h3C, B=8'h05, rsp_ready=1 -> rsp_valid exactly 2 cycles after handshake; rsp_data=8'h41, rsp_id=0, rsp_jump=1 (nonzero result).
- Req1: kSUB, A=8'h03, B=8'h05 -> rsp_data=8'hFE, rsp_id=1. Then kBGT A=8'h07, B=8'h09 -> rsp_data=0, rsp_jump=0.
- Both req_valid held high, 6 ops, rsp_ready=1 -> grant order 0,1,0,1,0,1; each response carries the matching operands' result and id.
- rsp_ready low 3 cycles in RESP with both requesters valid -> rsp_* stable, req_ready=0 throughout; grant is issued in the cycle rsp_ready rises.
- Reset_n pulsed low during ISSUE of kXOR 8'hF0^8'h0F -> no response, rr_ptr=0; next request is serviced normally.
- ALU_OPCHK_EN: opcode value outside op_mne -> rsp_err=1, rsp_data=8'h00, rsp_jump=0. Without the macro, rsp_err stays 0.
